// File: rtl/infix_tokenizer_if.sv
// Character-in / token-out handshake bundle for the infix tokenizer.
// The slave modport is the tokenizer's view; the master modport is the view of
// whoever feeds characters and consumes tokens.
interface infix_tokenizer_if #(
  parameter int N     = 13,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(N + 1);

  // character stream
  logic             ch_valid;
  logic             ch_ready;
  logic [7:0]       ch_data;
  logic             ch_last;

  // token stream
  logic             tok_valid;
  logic             tok_ready;
  logic [WIDTH-1:0] tok_value;
  logic             tok_is_op;
  logic             tok_last;
  logic [CW-1:0]    tok_count;
  logic             err;

  modport slave (
    input  ch_valid, ch_data, ch_last, tok_ready,
    output ch_ready, tok_valid, tok_value, tok_is_op, tok_last, tok_count, err
  );

  modport master (
    output ch_valid, ch_data, ch_last, tok_ready,
    input  ch_ready, tok_valid, tok_value, tok_is_op, tok_last, tok_count, err
  );
endinterface

// File: rtl/infix_tokenizer.sv
// Infix expression lexer: folds decimal digits (with an optional unary minus)
// into one two's-complement operand and passes operators/parens through as
// zero-extended ASCII codes, one token per handshake.
module infix_tokenizer #(
  parameter int N     = 13,
  parameter int WIDTH = 16
) (
  input logic              CLK,
  input logic              RST,
  infix_tokenizer_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] MAX_TOK = CW'(N);

  typedef enum logic [2:0] {
    S_EXPECT,
    S_NUM,
    S_FLUSH,
    S_AFTER,
    S_ERR
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             neg_reg;
  logic [7:0]       held_op_reg;
  logic             held_last_reg;
  logic             err_exit_reg;   // error hit on the final character: leave S_ERR next cycle
  logic [CW-1:0]    emit_cnt_reg;   // tokens loaded into the output register this expression
  logic             count_clr_reg;  // zero tok_count the cycle after the final handshake
  logic             tok_valid_reg;
  logic [WIDTH-1:0] tok_value_reg;
  logic             tok_is_op_reg;
  logic             tok_last_reg;
  logic [CW-1:0]    tok_count_reg;
  logic             err_reg;

  logic             ch_ready_w, ch_fire, tok_fire, out_free;
  logic             is_digit, is_op, is_space, is_minus, is_rparen, held_rparen;
  logic [WIDTH-1:0] digit_word, acc_step, ch_op_word, held_op_word;

  // per-cycle decision produced by the decoder below
  logic             emit_req, emit_is_op, emit_last, emit_block;
  logic             lex_err, hold_op, neg_set, acc_load;
  logic [WIDTH-1:0] emit_word, acc_word;
  state_t           step_state;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign is_digit     = (bus.ch_data >= 8'd48) && (bus.ch_data <= 8'd57);
  assign is_op        = bus.ch_data inside {8'd40, 8'd41, 8'd42, 8'd43, 8'd45, 8'd47};
  assign is_space     = bus.ch_data == 8'd32;
  assign is_minus     = bus.ch_data == 8'd45;
  assign is_rparen    = bus.ch_data == 8'd41;
  assign held_rparen  = held_op_reg == 8'd41;
  assign digit_word   = WIDTH'(bus.ch_data[3:0]);
  assign acc_step     = (acc_reg << 3) + (acc_reg << 1) + digit_word;
  assign ch_op_word   = WIDTH'(bus.ch_data);
  assign held_op_word = WIDTH'(held_op_reg);

  // A character is only taken when the output register is empty, so every
  // accepted character can produce a token without back-pressure.
  assign ch_ready_w = !tok_valid_reg && (state_reg != S_FLUSH) &&
                      !(state_reg == S_ERR && err_exit_reg);
  assign ch_fire    = bus.ch_valid && ch_ready_w;
  assign tok_fire   = tok_valid_reg && bus.tok_ready;
  assign out_free   = !tok_valid_reg || bus.tok_ready;
  assign emit_block = emit_req && (emit_cnt_reg == MAX_TOK);

  // Decode the current state and character into the action for this cycle.
  always_comb begin
    emit_req   = 1'b0;
    emit_word  = '0;
    emit_is_op = 1'b0;
    emit_last  = 1'b0;
    lex_err    = 1'b0;
    hold_op    = 1'b0;
    neg_set    = 1'b0;
    acc_load   = 1'b0;
    acc_word   = acc_reg;
    step_state = state_reg;
    unique case (state_reg)
      S_EXPECT: begin
        if (ch_fire) begin
          if (is_digit) begin
            acc_load = 1'b1;
            acc_word = digit_word;
            if (bus.ch_last) begin
              emit_req  = 1'b1;
              emit_word = apply_sign(digit_word, neg_reg);
              emit_last = 1'b1;
            end else begin
              step_state = S_NUM;
            end
          end else if (!is_op && !is_space) begin
            lex_err = 1'b1;
          end else if (neg_reg) begin
            lex_err = 1'b1;               // unary minus must be followed by a digit
          end else if (is_minus) begin
            if (bus.ch_last) lex_err = 1'b1;
            else             neg_set = 1'b1;
          end else if (is_space) begin
            if (bus.ch_last) lex_err = 1'b1;
          end else begin
            emit_req   = 1'b1;
            emit_word  = ch_op_word;
            emit_is_op = 1'b1;
            emit_last  = bus.ch_last;
            step_state = is_rparen ? S_AFTER : S_EXPECT;
          end
        end
      end
      S_NUM: begin
        if (ch_fire) begin
          if (is_digit) begin
            acc_load = 1'b1;
            acc_word = acc_step;
            if (bus.ch_last) begin
              emit_req  = 1'b1;
              emit_word = apply_sign(acc_step, neg_reg);
              emit_last = 1'b1;
            end
          end else if (is_op) begin
            // operand goes now, the operator waits one token slot in S_FLUSH
            emit_req   = 1'b1;
            emit_word  = apply_sign(acc_reg, neg_reg);
            hold_op    = 1'b1;
            step_state = S_FLUSH;
          end else if (is_space) begin
            emit_req   = 1'b1;
            emit_word  = apply_sign(acc_reg, neg_reg);
            emit_last  = bus.ch_last;
            step_state = S_AFTER;
          end else begin
            lex_err = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          emit_req   = 1'b1;
          emit_word  = held_op_word;
          emit_is_op = 1'b1;
          emit_last  = held_last_reg;
          step_state = held_rparen ? S_AFTER : S_EXPECT;
        end
      end
      S_AFTER: begin
        if (ch_fire) begin
          if (is_op) begin
            emit_req   = 1'b1;
            emit_word  = ch_op_word;
            emit_is_op = 1'b1;
            emit_last  = bus.ch_last;
            step_state = is_rparen ? S_AFTER : S_EXPECT;
          end else if (is_space) begin
            if (bus.ch_last) lex_err = 1'b1;
          end else begin
            lex_err = 1'b1;               // digit right after an operand, or illegal
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Tokenizer state machine and token output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= S_EXPECT;
      acc_reg       <= '0;
      neg_reg       <= 1'b0;
      held_op_reg   <= '0;
      held_last_reg <= 1'b0;
      err_exit_reg  <= 1'b0;
      emit_cnt_reg  <= '0;
      count_clr_reg <= 1'b0;
      tok_valid_reg <= 1'b0;
      tok_value_reg <= '0;
      tok_is_op_reg <= 1'b0;
      tok_last_reg  <= 1'b0;
      tok_count_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (count_clr_reg) begin
        tok_count_reg <= '0;
        count_clr_reg <= 1'b0;
      end
      if (tok_fire) begin
        tok_valid_reg <= 1'b0;
        tok_count_reg <= tok_count_reg + CW'(1);
      end

      if (state_reg == S_ERR) begin
        if (err_exit_reg || (ch_fire && bus.ch_last)) begin
          state_reg     <= S_EXPECT;
          err_reg       <= 1'b0;
          err_exit_reg  <= 1'b0;
          emit_cnt_reg  <= '0;
          tok_count_reg <= '0;
          neg_reg       <= 1'b0;
          acc_reg       <= '0;
        end
      end else if (lex_err || emit_block) begin
        // a token already in the output register is still delivered
        state_reg    <= S_ERR;
        err_reg      <= 1'b1;
        err_exit_reg <= (state_reg == S_FLUSH) ? held_last_reg : bus.ch_last;
        neg_reg      <= 1'b0;
        acc_reg      <= '0;
      end else begin
        state_reg <= step_state;
        if (acc_load) acc_reg <= acc_word;
        if (neg_set)  neg_reg <= 1'b1;
        if (hold_op) begin
          held_op_reg   <= bus.ch_data;
          held_last_reg <= bus.ch_last;
        end
        if (emit_req) begin
          tok_valid_reg <= 1'b1;
          tok_value_reg <= emit_word;
          tok_is_op_reg <= emit_is_op;
          tok_last_reg  <= emit_last;
          emit_cnt_reg  <= emit_cnt_reg + CW'(1);
          if (!emit_is_op) neg_reg <= 1'b0;
        end
      end

      // final token taken: start the next expression from a clean slate
      if (tok_fire && tok_last_reg) begin
        state_reg     <= S_EXPECT;
        neg_reg       <= 1'b0;
        acc_reg       <= '0;
        emit_cnt_reg  <= '0;
        count_clr_reg <= 1'b1;
      end
    end
  end

  assign bus.ch_ready  = ch_ready_w;
  assign bus.tok_valid = tok_valid_reg;
  assign bus.tok_value = tok_value_reg;
  assign bus.tok_is_op = tok_is_op_reg;
  assign bus.tok_last  = tok_last_reg;
  assign bus.tok_count = tok_count_reg;
  assign bus.err       = err_reg;
endmodule

// File: doc/infix_tokenizer.md
Name: infix_tokenizer

Overview:
- Front-end lexer for the expression solver.
- Consumes an ASCII character stream of one infix expression and emits tagged tokens, one per handshake: a value word plus an is-operator flag.
- This is the same token form the solver's infix array holds: row 0 carries values, row 1 carries the operator flag.
- Multi-digit decimals are folded into one operand. Unary minus is folded into a negative two's-complement operand.

Parameters:
- N, 13, maximum tokens per expression (solver array depth)
- WIDTH, 16, token value width

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous active-high reset
- ch_valid  input  1  character available
- ch_ready  output  1  character accepted when ch_valid && ch_ready
- ch_data  input  8  ASCII character
- ch_last  input  1  qualifies the final character of the expression
- tok_valid  output  1  token available
- tok_ready  input  1  token consumed when tok_valid && tok_ready
- tok_value  output  WIDTH  operand (two's complement) or operator ASCII code, zero-extended
- tok_is_op  output  1  1 = operator/paren, 0 = operand
- tok_last  output  1  final token of the expression
- tok_count  output  $clog2(N+1)  tokens emitted in current expression
- err  output  1  lexical or overflow error flag

Behaviour:
- Reset: all outputs 0; state S_EXPECT; accumulator, negate flag, held-operator register and count cleared. RST mid-expression abandons the expression with no token emitted.
- Character classes:
  - digits '0'-'9'
  - operators '+' (43), '-' (45), '*' (42), '/' (47), '(' (40), ')' (41)
  - space (32) ignored
  - anything else is illegal
- ch_ready = !tok_valid && state in {S_EXPECT, S_NUM, S_AFTER, S_ERR}. At most one character is accepted per cycle, and never while a token is waiting.
- Token output register: tok_* update only when a character is accepted or in S_FLUSH. tok_valid holds, and tok_value/tok_is_op/tok_last stay stable, until tok_ready.
- States:
  - S_EXPECT (operand expected: start, after an operator, after '('):
    - digit: acc = digit -> S_NUM.
    - '-': set neg (unary) -> S_EXPECT; a second unary '-' while neg is set is an error.
    - '(': emit op.
    - other operator or ')': emit op -> S_AFTER for ')', else stay.
  - S_NUM:
    - digit: acc = acc*10 + digit, modulo 2^WIDTH, no saturation.
    - operator: emit operand (neg ? -acc : acc), hold the operator -> S_FLUSH.
    - space: emit operand -> S_AFTER.
  - S_FLUSH: emit the held operator; next state is S_AFTER if it is ')', else S_EXPECT. No character is accepted.
  - S_AFTER (after operand or ')'): '-' is binary. Any operator: emit op -> S_EXPECT or S_AFTER (for ')'). A digit is an error.
  - S_ERR: err=1. Discards characters (ch_ready=1) until a character with ch_last is accepted, then -> S_EXPECT with err cleared on the next cycle.
- Unary '-' followed by anything but a digit is an error.
- ch_last handling:
  - Last digit: the operand is emitted the same cycle with acc updated and tok_last=1.
  - Last operator after a number: operand emitted, then the operator in S_FLUSH with tok_last=1.
  - Otherwise the token produced by that character carries tok_last.
  - Last space: the pending operand, if any, carries tok_last.
  - ch_last with neg pending, or with no token producible: error.
- After the tok_last handshake, state, neg and acc are cleared (S_EXPECT), and tok_count returns to 0 on the next cycle.
- tok_count increments on each token handshake.
- Emitting an (N+1)th token in one expression is an error, and that token is not emitted.
- Errors do not retract tokens already handed off.

Test Plan:
- "-4-(2*3)" with ch_last on ')', tok_ready=1 -> tokens (0xFFFC,0),(45,1),(40,1),(2,0),(42,1),(3,0),(41,1,last); tok_count reaches 7; err=0.
- "123+45" -> (123,0),(43,1),(45,0,last); ch_ready low during the S_FLUSH cycle after '+'.
- "70000", WIDTH=16 -> single token (4464,0,last) (wrap modulo 65536).
- "2+3" with tok_ready held 0 for 5 cycles on the first token -> tok_valid/value stay (2,0), ch_ready=0 throughout, no character lost; the sequence completes after release.
- "2#3": err rises on '#'; the remainder is discarded through ch_last; the next expression "7" -> (7,0,last), err=0.
- 15-token expression "1+1+1+1+1+1+1+1" with N=13 -> 13 tokens delivered, err on the 14th. A separate run asserts RST between "12" and "+": no token is emitted, outputs are 0, and a following "5" yields (5,0,last).
